// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall handling, load-use bubble insertion and a saturating bubble counter.
// Optional: define ID_EX_HAZARD_EN to enable load-use hazard detection.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [PC_W-1:0]   id_pc_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [1:0]        id_funct2_i,
    input  logic [1:0]        id_aluop_i,
    input  logic [10:0]       id_ctrl_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              ex_valid_o,
    output logic [PC_W-1:0]   ex_pc_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [1:0]        ex_funct2_o,
    output logic [1:0]        ex_aluop_o,
    output logic [10:0]       ex_ctrl_o,
    output logic              stall_id_o,
    output logic [15:0]       bubble_cnt_o
);

    // ctrl bit positions: {MemToReg, ByteEnable, MemRead, MemWrite, RegSrc, ALUSrc, RegWrite, CMP, BLT, BGE, JMP}
    localparam int unsigned C_MEMREAD  = 8;
    localparam int unsigned C_MEMWRITE = 7;
    localparam int unsigned C_ALUSRC   = 5;
    localparam int unsigned C_BLT      = 2;
    localparam int unsigned C_BGE      = 1;
    localparam int unsigned C_JMP      = 0;

    typedef enum logic [1:0] {
        LD_HOLD,
        LD_BUBBLE,
        LD_ID
    } load_e;

    logic  hazard;
    load_e load_sel;

`ifdef ID_EX_HAZARD_EN
    logic rs1_used;
    logic rs2_used;

    always_comb begin
        rs1_used = ~id_ctrl_i[C_JMP];
        rs2_used = ~id_ctrl_i[C_ALUSRC] | id_ctrl_i[C_MEMWRITE]
                 | id_ctrl_i[C_BLT] | id_ctrl_i[C_BGE];
        hazard   = ex_valid_o & ex_ctrl_o[C_MEMREAD] & id_valid_i
                 & (((ex_rd_o == id_rs1_i) & rs1_used)
                 |  ((ex_rd_o == id_rs2_i) & rs2_used));
    end
`else
    assign hazard = 1'b0;
`endif

    assign stall_id_o = (hazard | stall_i) & ~flush_i;

    always_comb begin
        load_sel = LD_ID;
        if (flush_i)
            load_sel = LD_BUBBLE;
        else if (stall_i)
            load_sel = LD_HOLD;
        else if (hazard)
            load_sel = LD_BUBBLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_funct2_o   <= '0;
            ex_aluop_o    <= '0;
            ex_ctrl_o     <= '0;
            bubble_cnt_o  <= '0;
        end else begin
            case (load_sel)
                LD_BUBBLE: begin
                    // data fields deliberately keep their previous values
                    ex_valid_o <= 1'b0;
                    ex_aluop_o <= '0;
                    ex_ctrl_o  <= '0;
                    if (bubble_cnt_o != '1)
                        bubble_cnt_o <= bubble_cnt_o + 16'd1;
                end
                LD_ID: begin
                    ex_valid_o    <= id_valid_i;
                    ex_pc_o       <= id_pc_i;
                    ex_rs1_data_o <= id_rs1_data_i;
                    ex_rs2_data_o <= id_rs2_data_i;
                    ex_imm_o      <= id_imm_i;
                    ex_rs1_o      <= id_rs1_i;
                    ex_rs2_o      <= id_rs2_i;
                    ex_rd_o       <= id_rd_i;
                    ex_funct2_o   <= id_funct2_i;
                    ex_aluop_o    <= id_valid_i ? id_aluop_i : '0;
                    ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a queue-based behavioural model.
module tb_id_ex_stage;

    localparam logic [10:0] K_MEMTOREG = 11'h400;
    localparam logic [10:0] K_MEMREAD  = 11'h100;
    localparam logic [10:0] K_MEMWRITE = 11'h080;
    localparam logic [10:0] K_ALUSRC   = 11'h020;
    localparam logic [10:0] K_REGWRITE = 11'h010;
    localparam logic [10:0] K_CMP      = 11'h008;
    localparam logic [10:0] K_BLT      = 11'h004;
    localparam logic [10:0] K_BGE      = 11'h002;
    localparam logic [10:0] K_JMP      = 11'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid_i = 1'b0;
    logic [31:0] id_pc_i = '0, id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
    logic [3:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic [1:0]  id_funct2_i = '0, id_aluop_i = '0;
    logic [10:0] id_ctrl_i = '0;
    logic        flush_i = 1'b0, stall_i = 1'b0;

    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [3:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [1:0]  ex_funct2_o, ex_aluop_o;
    logic [10:0] ex_ctrl_o;
    logic        stall_id_o;
    logic [15:0] bubble_cnt_o;

    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [3:0]  rs1, rs2, rd;
        logic [1:0]  f2, aluop;
        logic [10:0] ctrl;
        int unsigned cnt;
    } ex_t;

    ex_t m;

    id_ex_stage #(.DATA_W(32), .REG_AW(4), .PC_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_funct2_i(id_funct2_i), .id_aluop_i(id_aluop_i), .id_ctrl_i(id_ctrl_i),
        .flush_i(flush_i), .stall_i(stall_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .ex_funct2_o(ex_funct2_o), .ex_aluop_o(ex_aluop_o), .ex_ctrl_o(ex_ctrl_o),
        .stall_id_o(stall_id_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '{valid: 1'b0, pc: '0, rs1d: '0, rs2d: '0, imm: '0, rs1: '0, rs2: '0,
              rd: '0, f2: '0, aluop: '0, ctrl: '0, cnt: 0};
    endtask

    // Source registers the ID instruction reads, gathered as a list and matched against the EX load target.
    function automatic bit model_hazard();
`ifdef ID_EX_HAZARD_EN
        logic [3:0] srcs[$];
        if (!(m.valid && (m.ctrl & K_MEMREAD) != 0 && id_valid_i)) return 1'b0;
        if ((id_ctrl_i & K_JMP) == 0) srcs.push_back(id_rs1_i);
        if ((id_ctrl_i & K_ALUSRC) == 0 || (id_ctrl_i & (K_MEMWRITE | K_BLT | K_BGE)) != 0)
            srcs.push_back(id_rs2_i);
        foreach (srcs[k]) if (srcs[k] == m.rd) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_bubble();
        m.valid = 1'b0;
        m.aluop = '0;
        m.ctrl  = '0;
        m.cnt   = (m.cnt >= 65535) ? 65535 : m.cnt + 1;
    endtask

    task automatic model_step(input bit hz);
        if (flush_i) model_bubble();
        else if (stall_i) ;
        else if (hz) model_bubble();
        else begin
            m.valid = id_valid_i;
            m.pc = id_pc_i; m.rs1d = id_rs1_data_i; m.rs2d = id_rs2_data_i; m.imm = id_imm_i;
            m.rs1 = id_rs1_i; m.rs2 = id_rs2_i; m.rd = id_rd_i; m.f2 = id_funct2_i;
            m.aluop = id_valid_i ? id_aluop_i : 2'b00;
            m.ctrl  = id_valid_i ? id_ctrl_i : 11'h0;
        end
    endtask

    task automatic check_all();
        check("valid",  ex_valid_o,    m.valid);
        check("pc",     ex_pc_o,       m.pc);
        check("rs1d",   ex_rs1_data_o, m.rs1d);
        check("rs2d",   ex_rs2_data_o, m.rs2d);
        check("imm",    ex_imm_o,      m.imm);
        check("rs1",    ex_rs1_o,      m.rs1);
        check("rs2",    ex_rs2_o,      m.rs2);
        check("rd",     ex_rd_o,       m.rd);
        check("funct2", ex_funct2_o,   m.f2);
        check("aluop",  ex_aluop_o,    m.aluop);
        check("ctrl",   ex_ctrl_o,     m.ctrl);
        check("cnt",    bubble_cnt_o,  64'(m.cnt));
    endtask

    // Called one time unit after a rising edge with ID inputs already applied.
    task automatic cycle();
        bit hz;
        hz = model_hazard();
        #2;
        check("stall_id", stall_id_o, (hz | stall_i) & ~flush_i);
        @(posedge clk);
        model_step(hz);
        #1;
        check_all();
    endtask

    task automatic set_ins(input bit v, input logic [3:0] r1, input logic [3:0] r2,
                           input logic [3:0] rd, input logic [1:0] op, input logic [10:0] c);
        id_valid_i = v; id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
        id_aluop_i = op; id_ctrl_i = c;
        id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
        id_imm_i = $urandom; id_funct2_i = 2'($urandom);
        flush_i = 1'b0; stall_i = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        check("rst_stall_id", stall_id_o, 1'b0);
        rst = 1'b0;

        // addp
        set_ins(1, 4'd1, 4'd2, 4'd3, 2'b10, K_REGWRITE);
        cycle();
        check("addp_valid", ex_valid_o, 1'b1);
        check("addp_aluop", ex_aluop_o, 2'b10);
        check("addp_rd",    ex_rd_o,    4'd3);

        // lw rd=5 then addp rs1=5
        set_ins(1, 4'd1, 4'd7, 4'd5, 2'b00, K_MEMTOREG | K_MEMREAD | K_ALUSRC | K_REGWRITE);
        cycle();
        set_ins(1, 4'd5, 4'd6, 4'd7, 2'b10, K_REGWRITE);
        cycle();
`ifdef ID_EX_HAZARD_EN
        check("lu_bubble", ex_valid_o, 1'b0);
        check("lu_cnt", bubble_cnt_o, 16'd1);
        cycle();
`endif
        check("lu_addp_in", ex_rd_o, 4'd7);

        // lw rd=5 then sw rs2=5 (ALUSrc=1, MemWrite marks rs2 used)
        set_ins(1, 4'd1, 4'd7, 4'd5, 2'b00, K_MEMTOREG | K_MEMREAD | K_ALUSRC | K_REGWRITE);
        cycle();
        set_ins(1, 4'd2, 4'd5, 4'd0, 2'b00, K_MEMWRITE | K_ALUSRC);
        cycle();
        cycle();

        // lw rd=5 then addip with rs2 field 5: rs2 unused, no stall
        set_ins(1, 4'd1, 4'd7, 4'd5, 2'b00, K_MEMTOREG | K_MEMREAD | K_ALUSRC | K_REGWRITE);
        cycle();
        set_ins(1, 4'd2, 4'd5, 4'd8, 2'b10, K_ALUSRC | K_REGWRITE);
        cycle();
        check("addip_nostall_rd", ex_rd_o, 4'd8);

        // beq entry held for 3 stall cycles
        set_ins(1, 4'd1, 4'd2, 4'd0, 2'b01, K_CMP | K_BLT);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_ins(1, 4'($urandom), 4'($urandom), 4'($urandom), 2'b10, K_REGWRITE);
            stall_i = 1'b1;
            cycle();
            check("beq_hold_ctrl", ex_ctrl_o, K_CMP | K_BLT);
        end

        // flush together with stall and a pending load-use hazard
        set_ins(1, 4'd1, 4'd7, 4'd5, 2'b00, K_MEMTOREG | K_MEMREAD | K_ALUSRC | K_REGWRITE);
        cycle();
        set_ins(1, 4'd5, 4'd5, 4'd9, 2'b10, K_REGWRITE);
        stall_i = 1'b1; flush_i = 1'b1;
        cycle();
        check("flush_bubble", ex_valid_o, 1'b0);

        // asynchronous reset mid-cycle while a valid lw sits in EX
        set_ins(1, 4'd1, 4'd7, 4'd5, 2'b00, K_MEMTOREG | K_MEMREAD | K_ALUSRC | K_REGWRITE);
        cycle();
        stall_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", ex_valid_o, 1'b0);
        check("arst_ctrl",  ex_ctrl_o, 11'h0);
        check("arst_cnt",   bubble_cnt_o, 16'h0);
        check("arst_pc",    ex_pc_o, 32'h0);
        check("arst_stall", stall_id_o, 1'b1);
        #1 rst = 1'b0;
        model_reset();
        stall_i = 1'b0;
        cycle();

        for (int i = 0; i < 2000; i++) begin
            set_ins($urandom_range(0, 9) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)), 2'($urandom), 11'($urandom));
            flush_i = ($urandom_range(0, 9) == 0);
            stall_i = ($urandom_range(0, 6) == 0);
            cycle();
        end

        // saturate the bubble counter with back-to-back flushes
        set_ins(1, 4'd1, 4'd2, 4'd3, 2'b10, K_REGWRITE);
        flush_i = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            model_bubble();
        end
        #1;
        check_all();
        check("sat_cnt", bubble_cnt_o, 16'hFFFF);
        cycle();
        check("sat_hold", bubble_cnt_o, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline stage between the instruction decoder (ID) and the execute stage (EX). It latches the decoded control word and operand fields for one instruction per cycle. It inserts bubbles on flush or on a load-use hazard and holds its contents on a downstream stall. It drives the EX-stage control and data buses and returns a stall request to the fetch and decode stages.

## Interface
- DATA_W, 32, register operand and immediate width
- REG_AW, 4, register address width
- PC_W, 32, program counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  PC_W  instruction PC
- id_rs1_data_i, id_rs2_data_i  in  DATA_W  register read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register addresses
- id_funct2_i  in  2  funct2 field, forwarded to EX ALU decode
- id_aluop_i  in  2  ALUOp from decoder
- id_ctrl_i  in  11  {MemToReg, ByteEnable, MemRead, MemWrite, RegSrc, ALUSrc, RegWrite, CMP, BLT, BGE, JMP}
- flush_i  in  1  branch/jump taken in EX; kill the ID instruction
- stall_i  in  1  downstream (MEM) stall; hold all state
- ex_valid_o  out  1  EX entry valid
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct2_o, ex_aluop_o, ex_ctrl_o  out  as inputs  registered copies
- stall_id_o  out  1  hold PC and IF/ID register this cycle
- bubble_cnt_o  out  16  saturating count of inserted bubbles

## Operation
- Single register bank, updated on each rising clk edge. A bubble is valid=0 with aluop and ctrl all zero. Data fields of a bubble are held at their previous values.
- Next-state priority, highest first:
  - rst
  - flush_i: load bubble
  - stall_i: hold
  - hazard: load bubble
  - otherwise load ID fields, with valid = id_valid_i
- Gating: when id_valid_i=0, ctrl and aluop are loaded as zero.
- Load-use hazard (combinational), asserted when all of the following hold:
  - ex_valid_o=1
  - ex_ctrl_o.MemRead=1
  - id_valid_i=1
  - and either ex_rd_o==id_rs1_i with rs1 used, or ex_rd_o==id_rs2_i with rs2 used
- Operand-use rules:
  - rs1 is used unless JMP=1.
  - rs2 is used when ALUSrc=0, MemWrite=1, BLT=1 or BGE=1.
  - Register 0 is not special.
- stall_id_o = (hazard | stall_i) & ~flush_i.
- A hazard lasts exactly one cycle, because the inserted bubble clears MemRead.
- bubble_cnt_o increments by 1 on every edge that loads a bubble because of flush_i or a hazard. It does not increment on stall holds or on id_valid_i=0 loads. It saturates at 16'hFFFF.

## Timing
- Latency: ID inputs appear on ex_* outputs one clk edge later. There is no combinational path from id_* to ex_*.
- Only stall_id_o is combinational, from id_*, ex_* state, stall_i and flush_i.
- Reset values:
  - ex_valid_o=0, ex_ctrl_o=0, ex_aluop_o=0, ex_funct2_o=0
  - all data, address and PC outputs = 0
  - bubble_cnt_o=0
  - stall_id_o reflects only stall_i while in reset
- Reset mid-operation discards the held entry immediately (asynchronous). The first edge after deassertion loads normally.
- flush_i and stall_i in the same cycle: flush wins, the bubble is loaded, and stall_id_o=0.
- Hazard and stall_i in the same cycle: the register holds and the bubble is not counted. The hazard re-evaluates the following cycle.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection is active as described above.
- ID_EX_HAZARD_EN undefined:
  - hazard is tied to 0 and stall_id_o = stall_i & ~flush_i
  - bubble_cnt_o counts flush bubbles only
  - load-use interlock must then be handled by software scheduling

## Test plan
- Reset with rst pulsed asynchronously mid-cycle while holding a valid lw: ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=0 immediately, before the next edge.
- Issue an addp (aluop=2'b10, RegWrite, rd=3): the next cycle shows ex_valid_o=1, ex_aluop_o=2'b10, ex_rd_o=3 and data matching the inputs.
- Issue lw rd=5 then addp rs1=5 (macro on): stall_id_o=1 for one cycle, then a bubble in EX (ex_valid_o=0), bubble_cnt_o=1, and the addp enters on the following edge. With the macro off, stall_id_o=0 and the addp follows directly.
- Issue lw rd=5 then sw with rs2=5 and ALUSrc=1: the hazard fires because MemWrite marks rs2 as used. With rs2=5 on an addip, no stall occurs.
- Hold stall_i=1 for 3 cycles with a valid beq (BLT) entry: the EX outputs stay unchanged, stall_id_o=1, and bubble_cnt_o is unchanged.
- Assert flush_i together with stall_i and a pending hazard: a bubble is loaded, stall_id_o=0, and bubble_cnt_o increments by 1. Forcing the count to 16'hFFFF and flushing again leaves it at 16'hFFFF.
